// File: rtl/abacus_event_counters.sv
// abacus_event_counters: bank of 18 wrapping performance counters fed by the
// ABACUS per-cycle event strobes. Events are registered once (ev_q) and then
// accumulated. Counters, overflow flags, the instruction-match filter and the
// control word are reached through a single-cycle register port.
//
// Register port handshake: bus_req is a one-cycle strobe per access. A request
// in cycle M is always accepted (no stall, no error). A write lands at edge M.
// A read samples the pre-edge value at edge M. bus_ack is high for exactly
// cycle M+1, and bus_rdata carries the read value in that cycle only (0 otherwise).
module abacus_event_counters #(
    parameter int COUNTER_W    = 32,
    parameter bit RESET_ENABLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] abacus_instruction,
    input  logic        abacus_instruction_issued,
    input  logic        abacus_icache_request,
    input  logic        abacus_icache_miss,
    input  logic        abacus_icache_line_fill_in_progress,
    input  logic        abacus_dcache_request,
    input  logic        abacus_dcache_hit,
    input  logic        abacus_dcache_line_fill_in_progress,
    input  logic        abacus_branch_misprediction,
    input  logic        abacus_ras_misprediction,
    input  logic        abacus_issue_no_instruction_stat,
    input  logic        abacus_issue_no_id_stat,
    input  logic        abacus_issue_flush_stat,
    input  logic        abacus_unit_busy_stat,
    input  logic        abacus_issue_operands_not_ready_stat,
    input  logic        abacus_issue_hold_stat,
    input  logic        abacus_issue_multi_source_stat,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack
);

    localparam int N = 18;

    logic [N-1:0]         ev;
    logic [N-1:0]         ev_q;
    logic [COUNTER_W-1:0] cnt [N];
    logic [N-1:0]         ovf;
    logic [31:0]          mask;
    logic [31:0]          match;
    logic                 enable;

    logic                 wr;
    logic                 clear;
    logic                 ovf_w1c;
    logic [N-1:0]         wr_hit;
    logic [N-1:0]         inc;
    logic [N-1:0]         wrap;
    logic [31:0]          rd;

    // Raw event vector: event 0 is the cycle tick, event 17 the filtered issue.
    always_comb begin
        ev     = '0;
        ev[0]  = 1'b1;
        ev[1]  = abacus_instruction_issued;
        ev[2]  = abacus_icache_request;
        ev[3]  = abacus_icache_miss;
        ev[4]  = abacus_icache_line_fill_in_progress;
        ev[5]  = abacus_dcache_request;
        ev[6]  = abacus_dcache_hit;
        ev[7]  = abacus_dcache_line_fill_in_progress;
        ev[8]  = abacus_branch_misprediction;
        ev[9]  = abacus_ras_misprediction;
        ev[10] = abacus_issue_no_instruction_stat;
        ev[11] = abacus_issue_no_id_stat;
        ev[12] = abacus_issue_flush_stat;
        ev[13] = abacus_unit_busy_stat;
        ev[14] = abacus_issue_operands_not_ready_stat;
        ev[15] = abacus_issue_hold_stat;
        ev[16] = abacus_issue_multi_source_stat;
        ev[17] = abacus_instruction_issued && ((abacus_instruction & mask) == match);
    end

    // Decode bus writes and per-counter update conditions.
    always_comb begin
        wr      = bus_req && bus_we;
        clear   = wr && (bus_addr == 5'd31) && bus_wdata[1];
        ovf_w1c = wr && (bus_addr == 5'd30);
        wr_hit  = '0;
        inc     = '0;
        wrap    = '0;
        for (int i = 0; i < N; i++) begin
            wr_hit[i] = wr && (bus_addr == 5'(i));
            inc[i]    = enable && ev_q[i];
            // A bus write to this counter suppresses the increment, so no wrap.
            wrap[i]   = inc[i] && !wr_hit[i] && (cnt[i] == '1);
        end
    end

    // Event capture stage; CLEAR discards whatever would be captured.
    always_ff @(posedge clk) begin
        if (rst || clear) ev_q <= '0;
        else              ev_q <= ev;
    end

    // Counters: CLEAR beats a bus write, a bus write beats an increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || clear)   cnt[i] <= '0;
            else if (wr_hit[i]) cnt[i] <= bus_wdata[COUNTER_W-1:0];
            else if (inc[i])    cnt[i] <= cnt[i] + COUNTER_W'(1);
        end
    end

    // Overflow flags: write-1-to-clear, but a same-edge wrap keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst || clear) ovf <= '0;
        else              ovf <= (ovf & ~(ovf_w1c ? bus_wdata[N-1:0] : {N{1'b0}})) | wrap;
    end

    // Filter and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask   <= '0;
            match  <= '0;
            enable <= RESET_ENABLE;
        end else if (wr) begin
            if (bus_addr == 5'd28) mask   <= bus_wdata;
            if (bus_addr == 5'd29) match  <= bus_wdata;
            if (bus_addr == 5'd31) enable <= bus_wdata[0];
        end
    end

    // Read mux over the pre-edge register values; CLEAR always reads as 0.
    always_comb begin
        rd = '0;
        if (bus_addr < 5'd18) begin
            rd[COUNTER_W-1:0] = cnt[bus_addr];
        end else begin
            case (bus_addr)
                5'd28:   rd = mask;
                5'd29:   rd = match;
                5'd30:   rd[N-1:0] = ovf;
                5'd31:   rd[0] = enable;
                default: rd = '0;
            endcase
        end
    end

    // Response register: one ack per request, data only for reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= (bus_req && !bus_we) ? rd : 32'd0;
        end
    end

endmodule
